// File: rtl/pnr_pkg.sv
// rtl/pnr_pkg.sv - shared state encoding and default widths for the PNR trigger sequencer
package pnr_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        DELAY   = 3'd2,
        HOLDOFF = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int DEF_DELAY_W = 16;
    localparam int DEF_HOLD_W  = 16;
    localparam int DEF_CNT_W   = 32;

endpackage

// File: rtl/pnr_trig_sync.sv
// rtl/pnr_trig_sync.sv - external trigger synchroniser with selectable edge detect
module pnr_trig_sync
    import pnr_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic ADC_CLK,
    input  logic rst_i,
    input  logic trig_raw,
    input  logic edge_sel,
    output logic qe
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   last;

    assign last = sync[SYNC_STAGES-1];

    // qe is registered, giving SYNC_STAGES+1 cycles from the raw transition
    always_ff @(posedge ADC_CLK) begin
        if (rst_i) begin
            sync <= '0;
            hist <= 1'b0;
            qe   <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], trig_raw};
            hist <= last;
            qe   <= edge_sel ? (hist & ~last) : (last & ~hist);
        end
    end

endmodule

// File: rtl/pnr_trigger_sequencer.sv
// rtl/pnr_trigger_sequencer.sv - per-shot trigger, delayed sample strobe, holdoff and shot accounting
module pnr_trigger_sequencer
    import pnr_pkg::*;
#(
    parameter int DELAY_W     = DEF_DELAY_W,
    parameter int HOLD_W      = DEF_HOLD_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic               ADC_CLK,
    input  logic               rst_i,
    input  logic               ext_trig_i,
    input  logic               trig_edge_sel_i,
    input  logic               arm_i,
    input  logic               disarm_i,
    input  logic [DELAY_W-1:0] sample_delay_i,
    input  logic [HOLD_W-1:0]  holdoff_i,
    input  logic [CNT_W-1:0]   shot_target_i,
    input  logic               fifo_full_i,
    output logic               trigger_o,
    output logic               delayed_trigger_o,
    output logic               armed_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   shot_cnt_o,
    output logic [CNT_W-1:0]   missed_cnt_o,
    output logic [CNT_W-1:0]   dropped_cnt_o,
    output logic               overflow_o
);

    localparam logic [CNT_W-1:0]   CNT_ONE   = 1;
    localparam logic [DELAY_W-1:0] DELAY_ONE = 1;
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = 1;

    state_t             state;
    logic               qe;
    logic [DELAY_W-1:0] delay_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_lat;
    logic [CNT_W-1:0]   target_lat;

    pnr_trig_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .ADC_CLK  (ADC_CLK),
        .rst_i    (rst_i),
        .trig_raw (ext_trig_i),
        .edge_sel (trig_edge_sel_i),
        .qe       (qe)
    );

    assign armed_o = (state == ARMED) || (state == DELAY) || (state == HOLDOFF);
    assign done_o  = (state == DONE);

    always_ff @(posedge ADC_CLK) begin
        if (rst_i) begin
            state             <= IDLE;
            trigger_o         <= 1'b0;
            delayed_trigger_o <= 1'b0;
            delay_cnt         <= '0;
            hold_cnt          <= '0;
            hold_lat          <= '0;
            target_lat        <= '0;
            shot_cnt_o        <= '0;
            missed_cnt_o      <= '0;
            dropped_cnt_o     <= '0;
            overflow_o        <= 1'b0;
        end else begin
            trigger_o         <= 1'b0;
            delayed_trigger_o <= 1'b0;
            if (disarm_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (arm_i) begin
                            state         <= ARMED;
                            shot_cnt_o    <= '0;
                            missed_cnt_o  <= '0;
                            dropped_cnt_o <= '0;
                            overflow_o    <= 1'b0;
                        end
                    end
                    ARMED: begin
                        if (qe) begin
                            state      <= DELAY;
                            trigger_o  <= 1'b1;
                            delay_cnt  <= sample_delay_i;
                            hold_lat   <= holdoff_i;
                            target_lat <= shot_target_i;
                        end
                    end
                    DELAY: begin
                        if (qe && missed_cnt_o != '1)
                            missed_cnt_o <= missed_cnt_o + CNT_ONE;
                        if (delay_cnt == '0) begin
                            state    <= HOLDOFF;
                            hold_cnt <= hold_lat;
                            if (fifo_full_i) begin
                                overflow_o <= 1'b1;
                                if (dropped_cnt_o != '1)
                                    dropped_cnt_o <= dropped_cnt_o + CNT_ONE;
                            end else begin
                                delayed_trigger_o <= 1'b1;
                                if (shot_cnt_o != '1)
                                    shot_cnt_o <= shot_cnt_o + CNT_ONE;
                            end
                        end else begin
                            delay_cnt <= delay_cnt - DELAY_ONE;
                        end
                    end
                    HOLDOFF: begin
                        if (qe && missed_cnt_o != '1)
                            missed_cnt_o <= missed_cnt_o + CNT_ONE;
                        if (hold_cnt == '0) begin
                            if (target_lat != '0 && shot_cnt_o == target_lat)
                                state <= DONE;
                            else
                                state <= ARMED;
                        end else begin
                            hold_cnt <= hold_cnt - HOLD_ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pnr_trigger_sequencer.sv
// tb/tb_pnr_trigger_sequencer.sv - scoreboard bench for pnr_trigger_sequencer
module tb_pnr_trigger_sequencer;
    import pnr_pkg::*;

    logic        ADC_CLK;
    logic        rst_i;
    logic        ext_trig_i;
    logic        trig_edge_sel_i;
    logic        arm_i;
    logic        disarm_i;
    logic [15:0] sample_delay_i;
    logic [15:0] holdoff_i;
    logic [31:0] shot_target_i;
    logic        fifo_full_i;
    logic        trigger_o;
    logic        delayed_trigger_o;
    logic        armed_o;
    logic        done_o;
    logic [31:0] shot_cnt_o;
    logic [31:0] missed_cnt_o;
    logic [31:0] dropped_cnt_o;
    logic        overflow_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int exp_c;
    int p;
    int trig_q[$];
    int dly_q[$];

    pnr_trigger_sequencer dut (
        .ADC_CLK           (ADC_CLK),
        .rst_i             (rst_i),
        .ext_trig_i        (ext_trig_i),
        .trig_edge_sel_i   (trig_edge_sel_i),
        .arm_i             (arm_i),
        .disarm_i          (disarm_i),
        .sample_delay_i    (sample_delay_i),
        .holdoff_i         (holdoff_i),
        .shot_target_i     (shot_target_i),
        .fifo_full_i       (fifo_full_i),
        .trigger_o         (trigger_o),
        .delayed_trigger_o (delayed_trigger_o),
        .armed_o           (armed_o),
        .done_o            (done_o),
        .shot_cnt_o        (shot_cnt_o),
        .missed_cnt_o      (missed_cnt_o),
        .dropped_cnt_o     (dropped_cnt_o),
        .overflow_o        (overflow_o)
    );

    initial ADC_CLK = 1'b0;
    always #5 ADC_CLK = ~ADC_CLK;
    always @(posedge ADC_CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge ADC_CLK);
    endtask

    task automatic pulse_arm();
        arm_i = 1'b1;
        step(1);
        arm_i = 1'b0;
    endtask

    task automatic pulse_disarm();
        disarm_i = 1'b1;
        step(1);
        disarm_i = 1'b0;
    endtask

    // Raw edge driven at cycle p surfaces as trigger_o at p+4 and the sample at p+4+delay+1.
    task automatic expect_shot(input int at, input int dly, input bit sampled);
        trig_q.push_back(at + 4);
        if (sampled) dly_q.push_back(at + 5 + dly);
    endtask

    task automatic check_counts(input string tag, input int s, input int m, input int d, input int ov);
        check_eq({tag, "_shot"}, shot_cnt_o, s);
        check_eq({tag, "_missed"}, missed_cnt_o, m);
        check_eq({tag, "_dropped"}, dropped_cnt_o, d);
        check_eq({tag, "_overflow"}, overflow_o, ov);
    endtask

    always @(negedge ADC_CLK) begin
        if (trigger_o) begin
            if (trig_q.size() == 0) check_eq("trig_spurious", 1, 0);
            else begin
                exp_c = trig_q.pop_front();
                check_eq("trig_cycle", cyc, exp_c);
            end
        end
        if (delayed_trigger_o) begin
            if (dly_q.size() == 0) check_eq("dly_spurious", 1, 0);
            else begin
                exp_c = dly_q.pop_front();
                check_eq("dly_cycle", cyc, exp_c);
            end
        end
        if (trigger_o && delayed_trigger_o) check_eq("trig_excl", 1, 0);
    end

    initial begin
        rst_i = 1'b1; ext_trig_i = 1'b0; trig_edge_sel_i = 1'b0;
        arm_i = 1'b0; disarm_i = 1'b0; fifo_full_i = 1'b0;
        sample_delay_i = 16'd10; holdoff_i = 16'd5; shot_target_i = 32'd3;
        step(3);
        check_eq("rst_trig", trigger_o, 0);
        check_eq("rst_dly", delayed_trigger_o, 0);
        check_eq("rst_armed", armed_o, 0);
        check_eq("rst_done", done_o, 0);
        check_counts("rst", 0, 0, 0, 0);
        rst_i = 1'b0;
        step(2);

        // Delay 10, holdoff 5, three-shot run, then a fourth edge in DONE
        pulse_arm();
        check_eq("t1_armed", armed_o, 1);
        for (int i = 0; i < 3; i++) begin
            p = cyc; ext_trig_i = 1'b1; expect_shot(p, 10, 1);
            step(5); ext_trig_i = 1'b0; step(35);
        end
        check_eq("t1_done", done_o, 1);
        check_eq("t1_armed_off", armed_o, 0);
        check_counts("t1", 3, 0, 0, 0);
        ext_trig_i = 1'b1; step(5); ext_trig_i = 1'b0; step(35);
        check_eq("t1_done_hold", done_o, 1);
        check_eq("t1_shot_hold", shot_cnt_o, 3);

        // Zero delay, zero holdoff, continuous
        sample_delay_i = 16'd0; holdoff_i = 16'd0; shot_target_i = 32'd0;
        pulse_arm();
        check_counts("t2_clr", 0, 0, 0, 0);
        p = cyc; ext_trig_i = 1'b1; expect_shot(p, 0, 1);
        step(7);
        check_eq("t2_state_armed", int'(dut.state), int'(ARMED));
        ext_trig_i = 1'b0; step(5);

        // Second edge four cycles after the first lands in DELAY
        sample_delay_i = 16'd10; holdoff_i = 16'd5;
        p = cyc; ext_trig_i = 1'b1; expect_shot(p, 10, 1);
        step(2); ext_trig_i = 1'b0; step(2); ext_trig_i = 1'b1; step(2); ext_trig_i = 1'b0;
        step(30);
        check_counts("t3", 2, 1, 0, 0);

        // FIFO full on the sample cycle, then a normal shot
        pulse_disarm(); pulse_arm();
        p = cyc; fifo_full_i = 1'b1; ext_trig_i = 1'b1; expect_shot(p, 10, 0);
        step(2); ext_trig_i = 1'b0; step(25); fifo_full_i = 1'b0;
        check_counts("t4_drop", 0, 0, 1, 1);
        p = cyc; ext_trig_i = 1'b1; expect_shot(p, 10, 1);
        step(2); ext_trig_i = 1'b0; step(30);
        check_counts("t4_ok", 1, 0, 1, 1);

        // Disarm together with arm three cycles after trigger_o
        p = cyc; ext_trig_i = 1'b1; expect_shot(p, 10, 0);
        step(2); ext_trig_i = 1'b0; step(5);
        disarm_i = 1'b1; arm_i = 1'b1; step(1); disarm_i = 1'b0; arm_i = 1'b0;
        check_eq("t5_armed", armed_o, 0);
        check_eq("t5_state_idle", int'(dut.state), int'(IDLE));
        step(20);
        check_counts("t5", 1, 0, 1, 1);

        // Falling-edge select, then reset inside DELAY
        trig_edge_sel_i = 1'b1; step(2);
        pulse_arm();
        ext_trig_i = 1'b1; step(10);
        p = cyc; ext_trig_i = 1'b0; expect_shot(p, 10, 0);
        step(6);
        check_eq("t6_in_delay", int'(dut.state), int'(DELAY));
        rst_i = 1'b1; step(1);
        check_eq("t6_rst_armed", armed_o, 0);
        check_eq("t6_rst_trig", trigger_o, 0);
        check_counts("t6_rst", 0, 0, 0, 0);
        step(2); rst_i = 1'b0; step(20);
        check_eq("t6_dly", delayed_trigger_o, 0);
        check_eq("t6_done", done_o, 0);

        check_eq("trig_q_empty", trig_q.size(), 0);
        check_eq("dly_q_empty", dly_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
